// File: rtl/uart_rx_frame_pkg.sv
// uart_rx_frame_pkg: FSM state encodings and oversampling constants shared with the TX side
package uart_rx_frame_pkg;
    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: received-byte valid/ready channel towards the bus-side registers
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic frame_err;
    logic parity_err;
    logic overrun_err;
    modport master(output rx_data, rx_valid, frame_err, parity_err, overrun_err, input rx_ready);
    modport slave(input rx_data, rx_valid, frame_err, parity_err, overrun_err, output rx_ready);
endinterface

// File: rtl/uart_rx_frame_sipo.sv
// sipo_reg: right-shifting SIPO, new bit enters the MSB so an LSB-first stream lands in order
module sipo_reg #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);
    // shift one bit in per enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parallel_out <= '0;
        else if (en) parallel_out <= {serial_in, parallel_out[WIDTH-1:1]};
    end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x oversampled UART receiver with parity/stop checks and valid/ready output
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(parameter int DATA_BITS = 8) (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_tick,
    input  logic rx,
    input  logic parity_en,
    input  logic parity_odd,
    uart_rx_frame_if.master bus
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    logic rx_meta, rxs;
    logic [2:0] state;
    logic [3:0] tick_cnt, bit_cnt;
    logic par_en, par_odd, perr, stop_bit, deliver;
    logic [DATA_BITS-1:0] shift_data;
    logic last_tick;
    assign last_tick = tick_cnt == LAST_TICK;
    sipo_reg #(.WIDTH(DATA_BITS)) u_sipo (
        .clk(clk),
        .rst_n(rst_n),
        .en(baud_tick && last_tick && state == S_DATA),
        .serial_in(rxs),
        .parallel_out(shift_data)
    );
    // two-flop synchronizer for the asynchronous serial line, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rxs, rx_meta} <= 2'b11;
        else {rxs, rx_meta} <= {rx_meta, rx};
    end
    // frame FSM and tick/bit counters, advancing only on baud ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt <= '0;
            par_en <= 1'b0;
            par_odd <= 1'b0;
            perr <= 1'b0;
            stop_bit <= 1'b1;
            deliver <= 1'b0;
        end else begin
            deliver <= 1'b0;
            if (baud_tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                case (state)
                    S_IDLE: if (!rxs) begin
                        state <= S_START;
                        tick_cnt <= '0;
                    end
                    S_START: if (tick_cnt == MID_TICK) begin
                        state <= rxs ? S_IDLE : S_DATA;
                        tick_cnt <= '0;
                        bit_cnt <= '0;
                        par_en <= parity_en;
                        par_odd <= parity_odd;
                        perr <= 1'b0;
                    end
                    S_DATA: if (last_tick) begin
                        bit_cnt <= bit_cnt == LAST_BIT ? 4'd0 : bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) state <= par_en ? S_PARITY : S_STOP;
                    end
                    S_PARITY: if (last_tick) begin
                        perr <= ^shift_data ^ rxs ^ par_odd;
                        state <= S_STOP;
                    end
                    S_STOP: if (last_tick) begin
                        stop_bit <= rxs;
                        deliver <= 1'b1;
                        state <= rxs ? S_IDLE : S_WAIT_IDLE;
                    end
                    S_WAIT_IDLE: if (rxs) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
    // output holding register: load a finished frame, flag overrun if the old one is unread
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            bus.overrun_err <= 1'b0;
            if (deliver && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data <= shift_data;
                bus.frame_err <= ~stop_bit;
                bus.parity_err <= perr;
                bus.rx_valid <= 1'b1;
            end else if (deliver) begin
                bus.overrun_err <= 1'b1;
            end else if (bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and randomized frames checked against a scoreboard of expected bytes
module tb_uart_rx_frame;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic baud_tick = 1'b0;
    logic rx = 1'b1;
    logic parity_en = 1'b0;
    logic parity_odd = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int lat = 0;
    int ov_seen = 0;
    int ov_exp = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e_cur;

    uart_rx_frame_if bus();

    uart_rx_frame dut (
        .clk(clk),
        .rst_n(rst_n),
        .baud_tick(baud_tick),
        .rx(rx),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int d = 0;
        forever begin
            @(negedge clk);
            d = (d + 1) % 4;
            baud_tick = (d == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do begin
                @(negedge clk);
                #1;
            end while (!baud_tick);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd, input bit pflip,
                              input bit stop, input int low_after, input bit drop, input bit scramble);
        logic pb;
        parity_en = pen;
        parity_odd = podd;
        start_cyc = cyc;
        rx = 1'b0;
        wait_ticks(16);
        if (scramble) begin
            parity_en = 1'($urandom);
            parity_odd = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        pb = 1'($countones(d) % 2) ^ podd ^ pflip;
        if (pen) begin
            rx = pb;
            wait_ticks(16);
        end
        if (drop) ov_exp++;
        else exp_q.push_back({~stop, pen & pflip, d});
        rx = stop;
        wait_ticks(16 + low_after);
        rx = 1'b1;
        if (!stop) wait_ticks(16);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.overrun_err) ov_seen++;
            if (bus.rx_valid && bus.rx_ready) begin
                lat = cyc - start_cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", bus.rx_valid, 0);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("rx_data", bus.rx_data, e_cur[7:0]);
                    chk("parity_err", bus.parity_err, e_cur[8]);
                    chk("frame_err", bus.frame_err, e_cur[9]);
                end
            end
        end
    end

    initial begin
        logic [7:0] f = 8'hF0;
        logic [7:0] d;
        bit pen, podd, pflip, stop;
        bus.rx_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_parity_err", bus.parity_err, 0);
        chk("rst_overrun", bus.overrun_err, 0);
        rst_n = 1'b1;
        wait_ticks(20);

        send_frame(8'h55, 0, 0, 0, 1, 0, 0, 0);
        drain("t1_drain");
        chk("t1_latency_in_window", (lat >= 600 && lat <= 680), 1);

        send_frame(8'hA3, 1, 0, 0, 1, 0, 0, 0);
        send_frame(8'hA3, 1, 0, 1, 1, 0, 0, 0);
        drain("t2_drain");

        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(30);
        chk("t3_glitch_no_valid", bus.rx_valid, 0);
        send_frame(8'h3C, 0, 0, 0, 1, 0, 0, 0);
        drain("t3_drain");

        send_frame(8'h81, 0, 0, 0, 0, 32, 0, 0);
        drain("t4_drain");

        bus.rx_ready = 1'b0;
        send_frame(8'h11, 0, 0, 0, 1, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0, 1, 0, 1, 0);
        wait_ticks(4);
        chk("t5_valid_held", bus.rx_valid, 1);
        chk("t5_data_kept", bus.rx_data, 8'h11);
        chk("t5_overrun_count", ov_seen, ov_exp);
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        @(posedge clk);
        #1 chk("t5_valid_dropped", bus.rx_valid, 0);
        drain("t5_drain");

        parity_en = 1'b0;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = f[i];
            wait_ticks(16);
        end
        rx = f[4];
        wait_ticks(8);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rst_data", bus.rx_data, 0);
        chk("t6_rst_valid", bus.rx_valid, 0);
        chk("t6_rst_ferr", bus.frame_err, 0);
        chk("t6_rst_perr", bus.parity_err, 0);
        rx = 1'b1;
        rst_n = 1'b1;
        wait_ticks(20);
        chk("t6_no_valid", bus.rx_valid, 0);
        send_frame(8'h0F, 0, 0, 0, 1, 0, 0, 0);
        drain("t6_drain");

        repeat (24) begin
            d = 8'($urandom);
            pen = 1'($urandom);
            podd = 1'($urandom);
            pflip = pen && ($urandom_range(0, 3) == 0);
            stop = $urandom_range(0, 5) != 0;
            send_frame(d, pen, podd, pflip, stop, stop ? 0 : int'($urandom_range(0, 20)), 0, 1);
            wait_ticks($urandom_range(0, 20));
        end
        drain("rand_drain");
        chk("overrun_total", ov_seen, ov_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
